// File: rtl/intersection_phase_ctrl_pkg.sv
// Shared encodings for the intersection phase scheduler: phase states,
// car/ped light codes and the bundle of per-direction light outputs.
package intersection_phase_ctrl_pkg;

    typedef enum logic [2:0] {
        AR_NS  = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        AR_EW  = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5
    } phase_e;

    localparam logic [1:0] CAR_RED = 2'b00;
    localparam logic [1:0] CAR_YEL = 2'b01;
    localparam logic [1:0] CAR_GRN = 2'b10;

    localparam logic [1:0] PED_DONT  = 2'b00;
    localparam logic [1:0] PED_FLASH = 2'b01;
    localparam logic [1:0] PED_WALK  = 2'b10;

    typedef struct packed {
        logic [1:0] n_car;
        logic [1:0] s_car;
        logic [1:0] e_car;
        logic [1:0] w_car;
        logic [1:0] n_ped;
        logic [1:0] s_ped;
        logic [1:0] e_ped;
        logic [1:0] w_ped;
    } lights_t;

endpackage

// File: rtl/intersection_phase_ctrl_if.sv
// Request inputs and light/status outputs of the phase scheduler.
// ped_req bit order is N,S,E,W (bit3..0); ped_pend uses the same order.
interface intersection_phase_ctrl_if;
    logic [3:0] ped_req;
    logic       emg_req;
    logic       emg_dir;
    logic [1:0] n_car, s_car, e_car, w_car;
    logic [1:0] n_ped, s_ped, e_ped, w_ped;
    logic [2:0] phase;
    logic [7:0] cycle;
    logic [3:0] ped_pend;

    modport master (
        output ped_req, emg_req, emg_dir,
        input  n_car, s_car, e_car, w_car, n_ped, s_ped, e_ped, w_ped,
        input  phase, cycle, ped_pend
    );

    modport slave (
        input  ped_req, emg_req, emg_dir,
        output n_car, s_car, e_car, w_car, n_ped, s_ped, e_ped, w_ped,
        output phase, cycle, ped_pend
    );
endinterface

// File: rtl/intersection_phase_ctrl_ped_latch.sv
// Pedestrian request latch: holds pending buttons and records whether each
// axis had a request when its green started (the "served" flag).
module intersection_phase_ctrl_ped_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ped_req_i,
    input  logic       clr_ns_i,
    input  logic       clr_ew_i,
    output logic [3:0] pend_o,
    output logic [3:0] pend_d_o,
    output logic       served_ns_d_o,
    output logic       served_ew_d_o
);
    logic [3:0] pend_q, pend_d, seen;
    logic       served_ns_q, served_ns_d;
    logic       served_ew_q, served_ew_d;

    // A button seen on the green entry edge is absorbed into that green.
    always_comb begin
        seen        = pend_q | ped_req_i;
        pend_d      = seen & ~{clr_ns_i, clr_ns_i, clr_ew_i, clr_ew_i};
        served_ns_d = clr_ns_i ? |seen[3:2] : served_ns_q;
        served_ew_d = clr_ew_i ? |seen[1:0] : served_ew_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            served_ns_q <= 1'b0;
            served_ew_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            served_ns_q <= served_ns_d;
            served_ew_q <= served_ew_d;
        end
    end

    assign pend_o        = pend_q;
    assign pend_d_o      = pend_d;
    assign served_ns_d_o = served_ns_d;
    assign served_ew_d_o = served_ew_d;
endmodule

// File: rtl/intersection_phase_ctrl.sv
// Four-way intersection phase scheduler: timed green/yellow/all-red cycle with
// ped-request truncation and emergency pre-emption; all lights registered.
module intersection_phase_ctrl
    import intersection_phase_ctrl_pkg::*;
#(
    parameter int unsigned GREEN_T   = 40,
    parameter int unsigned YELLOW_T  = 8,
    parameter int unsigned ALLRED_T  = 4,
    parameter int unsigned MIN_GREEN = 16,
    parameter int unsigned PED_CLR_T = 6
) (
    input logic                      clk,
    input logic                      rst,
    intersection_phase_ctrl_if.slave bus
);
    localparam logic [7:0] AR_LAST     = 8'(ALLRED_T - 1);
    localparam logic [7:0] GRN_LAST    = 8'(GREEN_T - 1);
    localparam logic [7:0] YEL_LAST    = 8'(YELLOW_T - 1);
    localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
    localparam logic [7:0] WALK_LAST   = 8'(GREEN_T - 1 - PED_CLR_T);
    localparam logic [7:0] TRUNC_FLASH = 8'(MIN_GREEN - PED_CLR_T);

    phase_e     state_q, state_d;
    logic [7:0] cycle_q, cycle_d;
    lights_t    lights_q;
    logic       clr_ns, clr_ew, hold_d;
    logic [3:0] pend_q, pend_d;
    logic       served_ns_d, served_ew_d;

    intersection_phase_ctrl_ped_latch u_ped_latch (
        .clk           (clk),
        .rst           (rst),
        .ped_req_i     (bus.ped_req),
        .clr_ns_i      (clr_ns),
        .clr_ew_i      (clr_ew),
        .pend_o        (pend_q),
        .pend_d_o      (pend_d),
        .served_ns_d_o (served_ns_d),
        .served_ew_d_o (served_ew_d)
    );

    // Flash starts early when a pending opposite request will cut the green at MIN_GREEN.
    function automatic logic [1:0] ped_light(logic served, logic held, logic opp_pend,
                                             logic [7:0] cyc);
        if (!served || held) return PED_DONT;
        if (cyc > WALK_LAST || (opp_pend && cyc >= TRUNC_FLASH)) return PED_FLASH;
        return PED_WALK;
    endfunction

    function automatic lights_t decode(phase_e st, logic [7:0] cyc, logic srv_ns,
                                       logic srv_ew, logic [3:0] pend, logic held);
        lights_t l;
        l = '0;
        unique case (st)
            NS_GRN: begin
                l.n_car = CAR_GRN;
                l.s_car = CAR_GRN;
                l.n_ped = ped_light(srv_ns, held, |pend[1:0], cyc);
                l.s_ped = l.n_ped;
            end
            NS_YEL: begin
                l.n_car = CAR_YEL;
                l.s_car = CAR_YEL;
            end
            EW_GRN: begin
                l.e_car = CAR_GRN;
                l.w_car = CAR_GRN;
                l.e_ped = ped_light(srv_ew, held, |pend[3:2], cyc);
                l.w_ped = l.e_ped;
            end
            EW_YEL: begin
                l.e_car = CAR_YEL;
                l.w_car = CAR_YEL;
            end
            default: ;
        endcase
        return l;
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AR_NS:  if (cycle_q >= AR_LAST) state_d = NS_GRN;
            NS_GRN: begin
                if (bus.emg_req && !bus.emg_dir) state_d = NS_GRN;
                else if (bus.emg_req || cycle_q >= GRN_LAST ||
                         (|pend_q[1:0] && cycle_q >= MIN_LAST)) state_d = NS_YEL;
            end
            NS_YEL: if (cycle_q >= YEL_LAST) state_d = AR_EW;
            AR_EW:  if (cycle_q >= AR_LAST) state_d = EW_GRN;
            EW_GRN: begin
                if (bus.emg_req && bus.emg_dir) state_d = EW_GRN;
                else if (bus.emg_req || cycle_q >= GRN_LAST ||
                         (|pend_q[3:2] && cycle_q >= MIN_LAST)) state_d = EW_YEL;
            end
            EW_YEL: if (cycle_q >= YEL_LAST) state_d = AR_NS;
            default: state_d = AR_NS;
        endcase

        if (state_d != state_q) cycle_d = '0;
        else if (cycle_q == 8'hFF) cycle_d = cycle_q;
        else cycle_d = cycle_q + 8'd1;

        clr_ns = (state_q == AR_NS) && (state_d == NS_GRN);
        clr_ew = (state_q == AR_EW) && (state_d == EW_GRN);
        hold_d = bus.emg_req && ((state_d == NS_GRN && !bus.emg_dir) ||
                                 (state_d == EW_GRN &&  bus.emg_dir));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= AR_NS;
            cycle_q  <= '0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            lights_q <= decode(state_d, cycle_d, served_ns_d, served_ew_d, pend_d, hold_d);
        end
    end

    assign bus.phase    = state_q;
    assign bus.cycle    = cycle_q;
    assign bus.ped_pend = pend_q;
    assign bus.n_car    = lights_q.n_car;
    assign bus.s_car    = lights_q.s_car;
    assign bus.e_car    = lights_q.e_car;
    assign bus.w_car    = lights_q.w_car;
    assign bus.n_ped    = lights_q.n_ped;
    assign bus.s_ped    = lights_q.s_ped;
    assign bus.e_ped    = lights_q.e_ped;
    assign bus.w_ped    = lights_q.w_ped;
endmodule
